mem_prio_arbiter: RTL and testbench
===================================

# mem_prio_arbiter

Shares the single CPU memory port between `CNT` requesters, with fixed priority plus an anti-starvation override. Requester 0 is highest priority and is wired to the execute-stage data port; requester 1 is instruction fetch. The block tracks issued-but-unanswered transactions in an in-order ID queue, so responses return to the requester that issued them. It sits between the stage memory ports and the CPU's external `mem_req`/`mem_resp` pair, and replaces the round-robin arbiter there.

## Interface
- `CNT`, 2: number of requesters (≥2).
- `QUEUE_DEPTH`, 2: maximum outstanding slave transactions (≥1).
- `STARVE_LIMIT`, 4: consecutive lost arbitrations after which a lower-priority requester is forced through (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-low (reset when sampled 0 at `clk` rising edge).
- `master_req[CNT]`  decoupled.in  `mreq`  requests from stages.
- `master_resp[CNT]`  decoupled.out  `mtrans`  responses to stages.
- `slave_req`  decoupled.out  `mreq`  request to memory.
- `slave_resp`  decoupled.in  `mtrans`  response from memory.

## Operation
- Payloads pass through unmodified: `slave_req.data = master_req[gnt].data`; `master_resp[i].data = slave_resp.data` for every i.
- ID queue: FIFO of `$clog2(CNT)`-bit requester IDs, `QUEUE_DEPTH` entries. Push on `slave_req` fire. Pop on `slave_resp` fire. `full` = count == QUEUE_DEPTH.
- Accept condition: `can_issue = !full || slave_resp.fire()`, so a pop in the same cycle frees a slot.
- Grant selection (combinational, when no lock is held):
  - If any requester j>0 has `starve[j] >= STARVE_LIMIT` and is valid, grant the lowest such j.
  - Otherwise grant the lowest-index valid requester.
- Lock: if `slave_req.valid && !slave_req.ready`, register `lock_valid=1` and `lock_id=gnt`. While the lock is held, the grant is forced to `lock_id`, which keeps `slave_req` valid and stable. The lock clears on `slave_req` fire.
- Outputs:
  - `slave_req.valid = master_req[gnt].valid && can_issue`.
  - `master_req[i].ready = (i==gnt) && slave_req.ready && can_issue`.
- Starvation counters `starve[i]`, i>0, saturating at `STARVE_LIMIT`:
  - Reset to 0 when requester i fires.
  - Increment when requester i is valid and another requester fires.
  - Otherwise hold.
  - `starve[0]` does not exist.
- Response routing:
  - `master_resp[i].valid = slave_resp.valid && !empty && head==i`.
  - `slave_resp.ready = !empty && master_resp[head].ready`.
  - A response arriving with the queue empty is not accepted: `ready=0`. This is a protocol error, and the bench flags it.
- No flush input. Requesters discard squashed responses themselves; every issued request receives exactly one response.

## Timing
- Request path: zero latency. A master request fires in the same cycle as `slave_req` fires.
- Response path: zero latency, combinational `slave_resp` → `master_resp[head]`.
- Throughput: one issue and one retire per cycle, sustained, when `QUEUE_DEPTH` ≥ memory latency.
- Reset (rst=0 at edge):
  - Queue empty, count=0, `lock_valid=0`, all `starve`=0.
  - Outputs follow combinationally: `slave_req.valid=0` unless a master is valid; all `master_resp[*].valid=0`.
- Reset mid-operation drops all outstanding IDs. The memory side must also be reset.
- Simultaneous push and pop when full: allowed, count unchanged.
- Simultaneous push and pop when empty: a same-cycle pass-through response is impossible, because a response must follow its request by ≥1 cycle.
- Pointers wrap modulo `QUEUE_DEPTH`. Non-power-of-two depths must wrap explicitly.

## Test plan
All scenarios use CNT=2, QUEUE_DEPTH=2, STARVE_LIMIT=4, with memory response latency 1 unless stated.

- Reset: hold rst=0 for 2 cycles with both masters valid, then release. Required: queue count 0 and no `master_resp` valid; first grant goes to requester 0.
- Priority: both valid continuously, `slave_req.ready=1`. Required: requester 0 fires for 4 consecutive cycles, requester 1 fires on the 5th, then requester 0 resumes.
- Lock: requester 1 alone valid with `slave_req.ready=0`; requester 0 becomes valid next cycle; ready rises 3 cycles later. Required: `slave_req.data` stays requester 1's payload until it fires, then requester 0 is granted.
- Full backpressure: memory withholds responses; issue 2 requests. Required: the third is stalled (`master_req.ready=0`). Return one response and hold the third request valid. Required: the third fires in the same cycle as the pop; count stays 2.
- Routing: issue requester 0, requester 1, requester 0 back-to-back, with responses tagged A, B, C. Required: A→`master_resp[0]`, B→`master_resp[1]`, C→`master_resp[0]`.
- Response backpressure: `master_resp[1].ready=0` while the head is 1. Required: `slave_resp.ready=0` and the response is held until ready rises; no misroute to requester 0.

Source files
------------

// File: rtl/mem_prio_arbiter_if.sv
// Decoupled valid/ready channel carrying a W-bit payload between a producer and a consumer.
// Latency: none, this is a plain bundle of wires.
// Backpressure: the producer holds valid and data stable until the consumer raises ready.
// Ports: valid, data (producer to consumer), ready (consumer to producer).
// Modport master = producer side, modport slave = consumer side.
interface mem_prio_arbiter_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_prio_arbiter.sv
// Fixed-priority memory port arbiter with starvation override and in-order response routing.
// Latency: zero cycles on both the request path and the response path (combinational pass-through).
// Backpressure: issue stalls when the ID queue is full unless a response retires in the same cycle;
//   a stalled slave request is locked so valid and data stay stable; responses wait on the owner's ready.
// Ports: clk, rst (sync, active-low); master_req[CNT] in / master_resp[CNT] out toward the stages;
//   slave_req out / slave_resp in toward memory.
module mem_prio_arbiter #(
  parameter int CNT          = 2,
  parameter int QUEUE_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int REQ_W        = 32,
  parameter int RESP_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_prio_arbiter_if.slave  master_req  [CNT],
  mem_prio_arbiter_if.master master_resp [CNT],
  mem_prio_arbiter_if.master slave_req,
  mem_prio_arbiter_if.slave  slave_resp
);

  localparam int ID_W  = $clog2(CNT);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int SV_W  = $clog2(STARVE_LIMIT + 1);

  typedef logic [ID_W-1:0] id_t;

  // Flattened copies of the interface arrays so they can be indexed by the grant.
  logic [CNT-1:0]   mreq_vld;
  logic [CNT-1:0]   mreq_rdy;
  logic [CNT-1:0]   mresp_rdy;
  logic [REQ_W-1:0] mreq_dat [CNT];

  // ID queue state
  id_t              id_mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Lock and starvation state
  logic             lock_vld_q, lock_vld_d;
  id_t              lock_id_q, lock_id_d;
  logic [SV_W-1:0]  starve_q [1:CNT-1];
  logic [SV_W-1:0]  starve_d [1:CNT-1];

  id_t  gnt;
  id_t  head;
  logic empty, full, can_issue;
  logic req_fire, resp_fire;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign head      = id_mem_q[rd_ptr_q];

  for (genvar g = 0; g < CNT; g++) begin : g_port
    assign mreq_vld[g]          = master_req[g].valid;
    assign mreq_dat[g]          = master_req[g].data;
    assign master_req[g].ready  = mreq_rdy[g];
    assign mresp_rdy[g]         = master_resp[g].ready;
    assign master_resp[g].valid = slave_resp.valid && !empty && (head == id_t'(g));
    assign master_resp[g].data  = slave_resp.data;
    assign mreq_rdy[g]          = (gnt == id_t'(g)) && slave_req.ready && can_issue;
  end

  assign slave_resp.ready = !empty && mresp_rdy[head];
  assign resp_fire        = slave_resp.valid && slave_resp.ready;
  // A retiring response frees its slot in time for this cycle's issue.
  assign can_issue        = !full || resp_fire;

  assign slave_req.valid  = mreq_vld[gnt] && can_issue;
  assign slave_req.data   = mreq_dat[gnt];
  assign req_fire         = slave_req.valid && slave_req.ready;

  // Grant: a held lock wins outright; otherwise the lowest starved requester, else the lowest valid one.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    if (lock_vld_q) begin
      gnt   = lock_id_q;
      found = 1'b1;
    end
    for (int j = 1; j < CNT; j++) begin
      if (!found && mreq_vld[j] && (starve_q[j] >= SV_W'(STARVE_LIMIT))) begin
        gnt   = id_t'(j);
        found = 1'b1;
      end
    end
    for (int j = 0; j < CNT; j++) begin
      if (!found && mreq_vld[j]) begin
        gnt   = id_t'(j);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (req_fire) begin
      lock_vld_d = 1'b0;
    end else if (slave_req.valid) begin
      lock_vld_d = 1'b1;
      lock_id_d  = gnt;
    end
  end

  always_comb begin
    for (int j = 1; j < CNT; j++) begin
      starve_d[j] = starve_q[j];
      if (mreq_vld[j] && mreq_rdy[j]) begin
        starve_d[j] = '0;
      end else if (mreq_vld[j] && req_fire && (starve_q[j] < SV_W'(STARVE_LIMIT))) begin
        starve_d[j] = starve_q[j] + SV_W'(1);
      end
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (req_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (resp_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (req_fire && !resp_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!req_fire && resp_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      for (int j = 1; j < CNT; j++) begin
        starve_q[j] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      for (int j = 1; j < CNT; j++) begin
        starve_q[j] <= starve_d[j];
      end
    end
  end

  // Queue storage needs no reset: entries are only read when count says they are live.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      id_mem_q[wr_ptr_q] <= gnt;
    end
  end

endmodule

// File: tb/tb_mem_prio_arbiter.sv
module tb_mem_prio_arbiter;

  localparam int CNT   = 2;
  localparam int QD    = 2;
  localparam int LIMIT = 4;
  localparam logic [15:0] KEY = 16'h5A3C;

  typedef struct {
    int cycles;
    int pn0;
    int pn1;
    int psr;
    int pr0;
    int pr1;
    int lmin;
    int lmax;
    bit bogus;
  } phase_t;

  logic clk = 1'b0;
  logic rst;

  logic [CNT-1:0] drv_mreq_vld;
  logic [15:0]    drv_mreq_dat [CNT];
  logic           drv_sreq_rdy;
  logic [CNT-1:0] drv_mresp_rdy;
  logic           drv_srsp_vld;
  logic [15:0]    drv_srsp_dat;

  logic [CNT-1:0] mreq_rdy;
  logic [CNT-1:0] mresp_vld;
  logic [15:0]    mresp_dat [CNT];
  logic           sreq_vld;
  logic [15:0]    sreq_dat;
  logic           srsp_rdy;

  mem_prio_arbiter_if #(.W(16)) mreq_if  [CNT] ();
  mem_prio_arbiter_if #(.W(16)) mresp_if [CNT] ();
  mem_prio_arbiter_if #(.W(16)) sreq_if ();
  mem_prio_arbiter_if #(.W(16)) srsp_if ();

  for (genvar g = 0; g < CNT; g++) begin : g_bind
    assign mreq_if[g].valid  = drv_mreq_vld[g];
    assign mreq_if[g].data   = drv_mreq_dat[g];
    assign mreq_rdy[g]       = mreq_if[g].ready;
    assign mresp_vld[g]      = mresp_if[g].valid;
    assign mresp_dat[g]      = mresp_if[g].data;
    assign mresp_if[g].ready = drv_mresp_rdy[g];
  end
  assign sreq_vld      = sreq_if.valid;
  assign sreq_dat      = sreq_if.data;
  assign sreq_if.ready = drv_sreq_rdy;
  assign srsp_if.valid = drv_srsp_vld;
  assign srsp_if.data  = drv_srsp_dat;
  assign srsp_rdy      = srsp_if.ready;

  mem_prio_arbiter #(
    .CNT(CNT), .QUEUE_DEPTH(QD), .STARVE_LIMIT(LIMIT), .REQ_W(16), .RESP_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master_req(mreq_if),
    .master_resp(mresp_if),
    .slave_req(sreq_if),
    .slave_resp(srsp_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Environment: pending payloads per requester, memory in-flight list with release times.
  logic [15:0] pend [CNT][$];
  logic [15:0] exp_q [CNT][$];
  logic [15:0] mem_q [$];
  int          mem_t [$];
  int          last_t = 0;
  logic [7:0]  seq [CNT];

  // Reference model: who has waited how long, and which requester a stalled offer belongs to.
  int starve_m [CNT];
  int lock_m = -1;

  phase_t phases [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_cycle(input phase_t p);
    int  pn [CNT];
    int  pr [CNT];
    int  g;
    int  head_id;
    bit  exp_rsp_rdy, exp_rsp_fire, can, exp_vld, exp_fire;
    int  lat, t;

    pn[0] = p.pn0; pn[1] = p.pn1;
    pr[0] = p.pr0; pr[1] = p.pr1;

    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < CNT; i++) begin
      if (pend[i].size() < 4 && int'($urandom_range(99)) < pn[i]) begin
        pend[i].push_back({8'(i), seq[i]});
        seq[i] = seq[i] + 8'd1;
      end
      drv_mreq_vld[i]  = (pend[i].size() != 0);
      drv_mreq_dat[i]  = (pend[i].size() != 0) ? pend[i][0] : 16'h0;
      drv_mresp_rdy[i] = (int'($urandom_range(99)) < pr[i]);
    end
    drv_sreq_rdy = (int'($urandom_range(99)) < p.psr);
    if (mem_q.size() != 0 && mem_t[0] <= cyc) begin
      drv_srsp_vld = 1'b1;
      drv_srsp_dat = mem_q[0] ^ KEY;
    end else if (p.bogus && mem_q.size() == 0) begin
      drv_srsp_vld = 1'b1;
      drv_srsp_dat = 16'hDEAD;
    end else begin
      drv_srsp_vld = 1'b0;
      drv_srsp_dat = 16'h0;
    end

    @(negedge clk);
    // Expected grant from the arbitration rules.
    g = -1;
    if (lock_m >= 0) g = lock_m;
    for (int j = 1; j < CNT; j++)
      if (g < 0 && drv_mreq_vld[j] && starve_m[j] >= LIMIT) g = j;
    for (int j = 0; j < CNT; j++)
      if (g < 0 && drv_mreq_vld[j]) g = j;

    head_id      = (mem_q.size() != 0) ? int'(mem_q[0][15:8]) : -1;
    exp_rsp_rdy  = (head_id >= 0) && drv_mresp_rdy[head_id];
    exp_rsp_fire = drv_srsp_vld && exp_rsp_rdy;
    can          = (mem_q.size() < QD) || exp_rsp_fire;
    exp_vld      = (g >= 0) && drv_mreq_vld[g] && can;
    exp_fire     = exp_vld && drv_sreq_rdy;

    check("sreq_vld", 32'(sreq_vld), 32'(exp_vld));
    if (exp_vld) check("sreq_dat", 32'(sreq_dat), 32'(pend[g][0]));
    for (int i = 0; i < CNT; i++) begin
      if (drv_mreq_vld[i])
        check($sformatf("mreq_rdy%0d", i), 32'(mreq_rdy[i]), 32'(i == g && drv_sreq_rdy && can));
      check($sformatf("mresp_vld%0d", i), 32'(mresp_vld[i]), 32'(drv_srsp_vld && head_id == i));
    end
    check("srsp_rdy", 32'(srsp_rdy), 32'(exp_rsp_rdy));

    // Model state advance.
    if (exp_fire) begin
      exp_q[g].push_back(pend[g][0] ^ KEY);
      lock_m = -1;
    end else if (exp_vld) begin
      lock_m = g;
    end
    for (int j = 1; j < CNT; j++) begin
      if (exp_fire && g == j) starve_m[j] = 0;
      else if (exp_fire && drv_mreq_vld[j] && starve_m[j] < LIMIT) starve_m[j]++;
    end

    // Environment advance from the handshakes that actually happen at the next edge.
    if (sreq_vld && drv_sreq_rdy) begin
      lat = p.lmin + int'($urandom_range(p.lmax - p.lmin));
      t   = cyc + lat;
      if (t < last_t) t = last_t;
      last_t = t;
      mem_q.push_back(sreq_dat);
      mem_t.push_back(t);
    end
    for (int i = 0; i < CNT; i++)
      if (drv_mreq_vld[i] && mreq_rdy[i] && pend[i].size() != 0) void'(pend[i].pop_front());
    if (drv_srsp_vld && srsp_rdy && mem_q.size() != 0) begin
      void'(mem_q.pop_front());
      void'(mem_t.pop_front());
    end
  endtask

  // Response monitor: every delivered response must be the next one owed to that requester.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < CNT; i++) begin
        if (mresp_vld[i] && drv_mresp_rdy[i]) begin
          if (exp_q[i].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_extra%0d: got %0h, expected no response (cycle %0d)", i, mresp_dat[i], cyc);
          end else begin
            check($sformatf("resp_dat%0d", i), 32'(mresp_dat[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    //            cycles pn0 pn1 psr pr0 pr1 lmin lmax bogus
    phases[0] = '{  40, 100, 100, 100, 100, 100, 1,  1, 1'b0};  // strict priority with starvation override
    phases[1] = '{ 400,  50,  50,  70,  80,  80, 1,  4, 1'b0};  // mixed traffic
    phases[2] = '{  80,  60,  60, 100, 100, 100, 6, 10, 1'b0};  // queue full, issue waits on retire
    phases[3] = '{ 200,  60,  60,  80, 100,  20, 1,  3, 1'b0};  // requester 1 slow to take responses
    phases[4] = '{ 200,  40,  70,  25,  90,  90, 1,  2, 1'b0};  // slave_req stalls, lock held
    phases[5] = '{  60,   0,   0, 100, 100, 100, 1,  1, 1'b0};  // drain
    phases[6] = '{   6,   0,   0, 100, 100, 100, 1,  1, 1'b1};  // response with empty queue

    for (int i = 0; i < CNT; i++) begin
      seq[i]      = 8'd0;
      starve_m[i] = 0;
      pend[i].push_back({8'(i), seq[i]});
      seq[i]      = 8'd1;
      drv_mreq_vld[i]  = 1'b1;
      drv_mreq_dat[i]  = pend[i][0];
      drv_mresp_rdy[i] = 1'b1;
    end
    rst          = 1'b0;
    drv_sreq_rdy = 1'b0;
    drv_srsp_vld = 1'b1;
    drv_srsp_dat = 16'hBEEF;

    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_srsp_rdy", 32'(srsp_rdy), 32'(0));
      for (int i = 0; i < CNT; i++)
        check($sformatf("rst_mresp_vld%0d", i), 32'(mresp_vld[i]), 32'(0));
    end

    rst          = 1'b1;
    drv_mreq_vld = '0;
    drv_srsp_vld = 1'b0;
    mon_en       = 1'b1;

    for (int ph = 0; ph < 7; ph++)
      for (int c = 0; c < phases[ph].cycles; c++)
        run_cycle(phases[ph]);

    @(posedge clk);
    #1;
    for (int i = 0; i < CNT; i++)
      check($sformatf("undelivered%0d", i), 32'(exp_q[i].size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
